// File: rtl/simon_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : simon_fifo_sync_param
// Purpose  : Single-clock parametrised FIFO staging bytes/words between the
//            SIMON datapath and the host/UART framing logic. Inferred RAM
//            storage, optional first-word-fall-through output, programmable
//            almost-full/almost-empty thresholds, occupancy count, synchronous
//            flush and sticky overflow/underflow error flags.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            clr          - synchronous flush, active-high, beats all requests
//            din/wr_en    - write data / write request
//            rd_en        - read request (FWFT: pop the presented head)
//            dout         - read data
//            dout_valid   - dout holds valid data
//            full/empty, almost_full/almost_empty, count - registered status
//            overflow/underflow - sticky rejected-request flags
// Revision : 1.0 - initial release
// ============================================================================
module simon_fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    localparam logic [c_cnt_w-1:0]  c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_afull_cnt = c_cnt_w'(AFULL_TH);
    localparam logic [c_cnt_w-1:0]  c_aempty_cnt = c_cnt_w'(AEMPTY_TH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one   = c_addr_w'(1);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_full;
    logic                r_almost_full;
    logic                r_empty;
    logic                r_almost_empty;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [c_cnt_w-1:0]  w_count_nxt;

    // Acceptance uses the registered flags, so a request never sees the
    // effect of the other request issued in the same cycle.
    always_comb begin
        w_wr_acc    = wr_en & ~r_full;
        w_rd_acc    = rd_en & ~r_empty;
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // Pointers, count and flags. Flags are computed from the next-state
    // count so they line up with count in the cycle after the causing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (clr) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth_cnt);
            r_almost_full  <= (w_count_nxt >= c_afull_cnt);
            r_empty        <= (w_count_nxt == '0);
            r_almost_empty <= (w_count_nxt <= c_aempty_cnt);
            r_overflow     <= r_overflow  | (wr_en & r_full);
            r_underflow    <= r_underflow | (rd_en & r_empty);
        end
    end

    // Storage: no reset so the array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented combinationally; zero while empty so
            // reset and flush leave dout at a defined value.
            assign dout       = r_empty ? '0 : r_mem[r_rd_ptr];
            assign dout_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_dout;
            logic              r_dout_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (clr) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

    assign count        = r_count;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
